segre_csr_trap_controller: RTL

// - Sequences all access to the CSR register file: instruction CSR reads/writes, trap entry and MRET return.
// - Sits between decode/WB and the CSR register file.
// - Runs multi-cycle read-modify-write of MSTATUS/MEPC/MCAUSE, then flushes and redirects the fetch PC.
// - Sole master of the register file's we/exc_we/r_id/w_id buses.

---
 rtl/segre_pkg.sv | 29 ++
 rtl/segre_mstatus_update.sv | 22 ++
 rtl/segre_csr_trap_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/segre_pkg.sv
// Shared CSR constants and the trap/MRET sequencer state encoding.
package segre_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int CSR_ID_BIT_SIZE = 2;

    localparam logic [CSR_ID_BIT_SIZE:0] MSTATUS_ID = 3'd0;
    localparam logic [CSR_ID_BIT_SIZE:0] MTVEC_ID   = 3'd1;
    localparam logic [CSR_ID_BIT_SIZE:0] MEPC_ID    = 3'd2;
    localparam logic [CSR_ID_BIT_SIZE:0] MCAUSE_ID  = 3'd3;

    localparam int         MSTATUS_MIE_BIT  = 3;
    localparam int         MSTATUS_MPIE_BIT = 7;
    localparam int         MSTATUS_MPP_LSB  = 11;
    localparam logic [1:0] MPP_MACHINE      = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        T_RD_TVEC,
        T_RD_STAT,
        T_WRITE,
        T_REDIR,
        M_RD_EPC,
        M_RD_STAT,
        M_WRITE,
        M_REDIR
    } trap_state_e;

endpackage

// File: rtl/segre_mstatus_update.sv
// Computes the mstatus value written on trap entry (is_trap=1) or MRET (is_trap=0).
module segre_mstatus_update
    import segre_pkg::*;
(
    input  logic [WORD_SIZE-1:0] stat,
    input  logic                 is_trap,
    output logic [WORD_SIZE-1:0] new_mstatus
);

    always_comb begin
        new_mstatus = stat;
        if (is_trap) begin
            new_mstatus[MSTATUS_MPIE_BIT]               = stat[MSTATUS_MIE_BIT];
            new_mstatus[MSTATUS_MIE_BIT]                = 1'b0;
            new_mstatus[MSTATUS_MPP_LSB +: 2]           = MPP_MACHINE;
        end else begin
            new_mstatus[MSTATUS_MIE_BIT]                = stat[MSTATUS_MPIE_BIT];
            new_mstatus[MSTATUS_MPIE_BIT]               = 1'b1;
        end
    end

endmodule

// File: rtl/segre_csr_trap_controller.sv
// Sole master of the CSR register file: passes instruction CSR accesses through in IDLE
// and sequences the read-modify-write for trap entry and MRET, ending in a flush/redirect.
module segre_csr_trap_controller
    import segre_pkg::*;
#(
    parameter logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFC,
    parameter bit          TRAP_PRIO_HI = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       exc_valid_i,
    input  logic [WORD_SIZE-1:0]       exc_cause_i,
    input  logic [WORD_SIZE-1:0]       exc_pc_i,
    input  logic                       mret_valid_i,
    input  logic                       csr_valid_i,
    output logic                       csr_ready_o,
    input  logic                       csr_we_i,
    input  logic [CSR_ID_BIT_SIZE:0]   csr_id_i,
    input  logic [WORD_SIZE-1:0]       csr_wdata_i,
    output logic [WORD_SIZE-1:0]       csr_rdata_o,
    output logic                       rf_we_o,
    output logic                       rf_exc_we_o,
    output logic [CSR_ID_BIT_SIZE:0]   rf_r_id_o,
    output logic [CSR_ID_BIT_SIZE:0]   rf_w_id_o,
    output logic [WORD_SIZE-1:0]       rf_w_data_o,
    output logic [WORD_SIZE-1:0]       rf_mstatus_o,
    output logic [WORD_SIZE-1:0]       rf_mtvec_o,
    output logic [WORD_SIZE-1:0]       rf_mepc_o,
    output logic [WORD_SIZE-1:0]       rf_mcause_o,
    input  logic [WORD_SIZE-1:0]       rf_rdata_i,
    output logic                       flush_o,
    output logic                       redirect_o,
    output logic [WORD_SIZE-1:0]       redirect_pc_o,
    output logic                       busy_o
);

    trap_state_e          state;
    logic [WORD_SIZE-1:0] tvec_q, stat_q, epc_q, cause_q, pc_q;
    logic [WORD_SIZE-1:0] mstatus_new;
    logic                 take_trap, take_mret;

    assign take_trap = exc_valid_i && (TRAP_PRIO_HI || !mret_valid_i);
    assign take_mret = mret_valid_i && !take_trap;

    segre_mstatus_update u_mstatus_update (
        .stat        (stat_q),
        .is_trap     (state == T_WRITE),
        .new_mstatus (mstatus_new)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tvec_q  <= '0;
            stat_q  <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_trap || take_mret) begin
                        pc_q    <= exc_pc_i;
                        cause_q <= exc_cause_i;
                    end
                    if (take_trap)      state <= T_RD_TVEC;
                    else if (take_mret) state <= M_RD_EPC;
                end
                T_RD_TVEC: begin tvec_q <= rf_rdata_i; state <= T_RD_STAT; end
                T_RD_STAT: begin stat_q <= rf_rdata_i; state <= T_WRITE;   end
                T_WRITE:   state <= T_REDIR;
                T_REDIR:   state <= IDLE;
                M_RD_EPC:  begin epc_q  <= rf_rdata_i; state <= M_RD_STAT; end
                M_RD_STAT: begin stat_q <= rf_rdata_i; state <= M_WRITE;   end
                M_WRITE:   state <= M_REDIR;
                M_REDIR:   state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_ready_o   = 1'b0;
        csr_rdata_o   = rf_rdata_i;
        rf_we_o       = 1'b0;
        rf_exc_we_o   = 1'b0;
        rf_r_id_o     = '0;
        rf_w_id_o     = '0;
        rf_w_data_o   = '0;
        rf_mstatus_o  = '0;
        rf_mtvec_o    = '0;
        rf_mepc_o     = '0;
        rf_mcause_o   = '0;
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        busy_o        = (state != IDLE);
        case (state)
            IDLE: begin
                rf_r_id_o   = csr_id_i;
                rf_w_id_o   = csr_id_i;
                rf_w_data_o = csr_wdata_i;
                if (!(take_trap || take_mret)) begin
                    csr_ready_o = 1'b1;
                    rf_we_o     = csr_valid_i && csr_we_i;
                end
            end
            T_RD_TVEC: rf_r_id_o = MTVEC_ID;
            T_RD_STAT: rf_r_id_o = MSTATUS_ID;
            T_WRITE: begin
                rf_exc_we_o  = 1'b1;
                rf_mstatus_o = mstatus_new;
                rf_mtvec_o   = tvec_q;
                rf_mepc_o    = pc_q;
                rf_mcause_o  = cause_q;
            end
            T_REDIR: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = tvec_q & MTVEC_MASK;
            end
            M_RD_EPC:  rf_r_id_o = MEPC_ID;
            M_RD_STAT: rf_r_id_o = MSTATUS_ID;
            M_WRITE: begin
                rf_we_o     = 1'b1;
                rf_w_id_o   = MSTATUS_ID;
                rf_w_data_o = mstatus_new;
            end
            M_REDIR: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = epc_q;
            end
            default: ;
        endcase
        // Reset must also suppress any in-flight RF write, so it overrides every output.
        if (rst_i) begin
            csr_ready_o   = 1'b0;
            csr_rdata_o   = '0;
            rf_we_o       = 1'b0;
            rf_exc_we_o   = 1'b0;
            rf_r_id_o     = '0;
            rf_w_id_o     = '0;
            rf_w_data_o   = '0;
            rf_mstatus_o  = '0;
            rf_mtvec_o    = '0;
            rf_mepc_o     = '0;
            rf_mcause_o   = '0;
            flush_o       = 1'b0;
            redirect_o    = 1'b0;
            redirect_pc_o = '0;
            busy_o        = 1'b0;
        end
    end

endmodule
